par_unfolded_fir: RTL and testbench

PAR_UNFOLDED_FIR -- requirements
Module: par_unfolded_fir

---
 rtl/fir_pkg.sv | 34 +++
 rtl/fir_lane_mac.sv | 74 +++++++
 rtl/par_unfolded_fir.sv | 87 ++++++++
 tb/tb_par_unfolded_fir.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : fir_pkg
// Description : Shared constants and width helpers for par_unfolded_fir.
//               Build option: FIR_PIPE_EN (adds a product register stage).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
package fir_pkg;

  localparam int DEF_NB     = 7;
  localparam int DEF_N_TAPS = 11;
  localparam int DEF_J      = 3;

`ifdef FIR_PIPE_EN
  localparam int LATENCY = 3;
`else
  localparam int LATENCY = 2;
`endif

  function automatic int acc_width(input int nb, input int n_taps);
    return 2*nb + $clog2(n_taps);
  endfunction

  // Output is a Q1.(NB-1) rescale of the full-precision accumulator.
  function automatic int out_lsb(input int nb);
    return nb - 1;
  endfunction

  function automatic int out_msb(input int nb);
    return 2*nb - 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_lane_mac.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : fir_lane_mac
// Description : One-lane multiply-accumulate over an N_TAPS sample window.
//               Build option: FIR_PIPE_EN registers the products.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module fir_lane_mac
  import fir_pkg::*;
#(
  parameter int NB     = DEF_NB,
  parameter int N_TAPS = DEF_N_TAPS
) (
`ifdef FIR_PIPE_EN
  input  logic                   clk_i,
  input  logic                   rst_i,
`endif
  input  logic [N_TAPS*NB-1:0]   win_i,
  input  logic [N_TAPS*NB-1:0]   h_i,
  output logic [NB-1:0]          y_o
);

  localparam int PW      = 2*NB;
  localparam int AW      = acc_width(NB, N_TAPS);
  localparam int OUT_LSB = out_lsb(NB);

  logic signed [PW-1:0] prod_d [N_TAPS];
  logic signed [PW-1:0] prod   [N_TAPS];
  logic signed [AW-1:0] acc;

  always_comb begin
    for (int i = 0; i < N_TAPS; i++) begin
      prod_d[i] = PW'($signed(win_i[i*NB +: NB])) * PW'($signed(h_i[i*NB +: NB]));
    end
  end

`ifdef FIR_PIPE_EN
  logic signed [PW-1:0] prod_q [N_TAPS];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N_TAPS; i++) begin
      if (rst_i) begin
        prod_q[i] <= '0;
      end else begin
        prod_q[i] <= prod_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_TAPS; i++) begin
      prod[i] = prod_q[i];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < N_TAPS; i++) begin
      prod[i] = prod_d[i];
    end
  end
`endif

  always_comb begin
    acc = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      acc = acc + AW'(prod[i]);
    end
  end

  // Truncating cast keeps the wrap-around behaviour on overflow.
  assign y_o = NB'(acc >>> OUT_LSB);

endmodule
`default_nettype wire

// File: rtl/par_unfolded_fir.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : par_unfolded_fir
// Description : J-way unfolded direct-form FIR, J samples per valid cycle.
//               Build option: FIR_PIPE_EN (latency 3 instead of 2).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module par_unfolded_fir
  import fir_pkg::*;
#(
  parameter int NB     = DEF_NB,
  parameter int N_TAPS = DEF_N_TAPS,
  parameter int J      = DEF_J
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  VIN,
  input  logic [J*NB-1:0]       DIN,
  input  logic [N_TAPS*NB-1:0]  H,
  output logic                  VOUT,
  output logic [J*NB-1:0]       DOUT
);

  localparam int HL = N_TAPS - 1;
  localparam int SL = HL + J;

  logic [J*NB-1:0]    din_q;
  logic [HL*NB-1:0]   hist_q;
  logic [HL*NB-1:0]   hist_d;
  logic [SL*NB-1:0]   seq;
  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] vld_d;
  logic [J*NB-1:0]    dout_q;
  logic [J*NB-1:0]    dout_d;

  // Sample stream, oldest at index 0: history followed by the current block.
  assign seq    = {din_q, hist_q};
  assign hist_d = seq[SL*NB-1 -: HL*NB];
  assign vld_d  = {vld_q[LATENCY-2:0], VIN};

  always_ff @(posedge CLK) begin
    if (RST) begin
      din_q  <= '0;
      hist_q <= '0;
      vld_q  <= '0;
      dout_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (VIN) begin
        din_q  <= DIN;
        hist_q <= hist_d;
      end
      if (vld_q[LATENCY-2]) begin
        dout_q <= dout_d;
      end
    end
  end

  for (genvar k = 0; k < J; k++) begin : g_lane
    logic [N_TAPS*NB-1:0] win;

    always_comb begin
      win = '0;
      for (int i = 0; i < N_TAPS; i++) begin
        win[i*NB +: NB] = seq[(HL+k-i)*NB +: NB];
      end
    end

    fir_lane_mac #(
      .NB     (NB),
      .N_TAPS (N_TAPS)
    ) u_mac (
`ifdef FIR_PIPE_EN
      .clk_i  (CLK),
      .rst_i  (RST),
`endif
      .win_i  (win),
      .h_i    (H),
      .y_o    (dout_d[k*NB +: NB])
    );
  end

  assign VOUT = vld_q[LATENCY-1];
  assign DOUT = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_par_unfolded_fir.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_par_unfolded_fir
// Description : Directed and model-checked bench for par_unfolded_fir.
//               Honours FIR_PIPE_EN (expects latency 3 when defined).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_par_unfolded_fir;

  localparam int NB = 7;
  localparam int NT = 11;
  localparam int J  = 3;
`ifdef FIR_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              VIN = 1'b0;
  logic [J*NB-1:0]   DIN = '0;
  logic [NT*NB-1:0]  H   = '0;
  logic              VOUT;
  logic [J*NB-1:0]   DOUT;

  par_unfolded_fir #(.NB(NB), .N_TAPS(NT), .J(J)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .VIN  (VIN),
    .DIN  (DIN),
    .H    (H),
    .VOUT (VOUT),
    .DOUT (DOUT)
  );

  always #5 CLK = ~CLK;

  int              ncmp = 0;
  int              nfail = 0;
  int              nrec = 0;
  logic            vrec [0:1023];
  logic [J*NB-1:0] drec [0:1023];
  logic            ev   [0:1023];
  logic [J*NB-1:0] ed   [0:1023];
  int              xs   [0:2047];
  int              nx;
  int              blocks;
  logic            v;
  logic [J*NB-1:0] rd;
  logic [J*NB-1:0] yb;
  logic [J*NB-1:0] last;
  logic [NB-1:0]   xv;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    vrec[nrec] = VOUT;
    drec[nrec] = DOUT;
    nrec++;
  endtask

  task automatic apply(input logic vv, input logic [J*NB-1:0] d);
    VIN = vv;
    DIN = d;
    tick();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    VIN = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  function automatic logic [J*NB-1:0] pk(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                          input logic [NB-1:0] c);
    return {c, b, a};
  endfunction

  function automatic logic [NT*NB-1:0] hset(input int i, input logic [NB-1:0] val);
    logic [NT*NB-1:0] r;
    r = '0;
    r[i*NB +: NB] = val;
    return r;
  endfunction

  // Direct convolution against the whole recorded sample history.
  function automatic logic [NB-1:0] ymodel(input int n);
    int            acc;
    logic [NB-1:0] hv;
    acc = 0;
    for (int i = 0; i < NT; i++) begin
      if (n - i >= 0) begin
        hv  = H[i*NB +: NB];
        acc = acc + int'($signed(hv)) * xs[n-i];
      end
    end
    return NB'(acc >>> (NB-1));
  endfunction

  initial begin
    // Reset state
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    check("rst_vout", VOUT, 1'b0);
    check("rst_dout", DOUT, '0);

    // Impulse through tap 0, idle DIN carries junk that must be ignored
    do_reset();
    H = hset(0, 32);
    nrec = 0;
    apply(1'b1, pk(40, 0, 0));
    repeat (LAT+1) apply(1'b0, pk(5, 5, 5));
    for (int i = 0; i <= LAT+1; i++) check("imp_vout", vrec[i], (i == LAT-1));
    check("imp_dout", drec[LAT-1], pk(20, 0, 0));
    check("imp_hold", drec[LAT], pk(20, 0, 0));

    // Tap 1 reaches from lane 2 of one block into lane 0 of the next
    do_reset();
    H = hset(1, 32);
    nrec = 0;
    apply(1'b1, pk(0, 0, 40));
    apply(1'b1, pk(0, 0, 0));
    repeat (LAT) apply(1'b0, '0);
    for (int i = 0; i <= LAT+1; i++) check("xl_vout", vrec[i], (i == LAT-1) || (i == LAT));
    check("xl_dout0", drec[LAT-1], pk(0, 0, 0));
    check("xl_dout1", drec[LAT], pk(20, 0, 0));

    // History held across a 3-cycle VIN gap
    do_reset();
    H = hset(3, 32);
    nrec = 0;
    apply(1'b1, pk(40, 0, 0));
    repeat (3) apply(1'b0, pk(9, 9, 9));
    apply(1'b1, pk(0, 0, 0));
    repeat (LAT) apply(1'b0, '0);
    for (int i = 0; i <= LAT+4; i++) check("gap_vout", vrec[i], (i == LAT-1) || (i == LAT+3));
    check("gap_dout0", drec[LAT-1], pk(0, 0, 0));
    check("gap_hold", drec[LAT+1], pk(0, 0, 0));
    check("gap_dout1", drec[LAT+3], pk(20, 0, 0));

    // Overflow wrap: all coefficients and samples 63
    do_reset();
    H = {NT{7'd63}};
    nrec = 0;
    repeat (4) apply(1'b1, pk(63, 63, 63));
    repeat (LAT) apply(1'b0, '0);
    check("ovf_b0", drec[LAT-1], pk(62, 124, 58));
    check("ovf_b1", drec[LAT],   pk(120, 54, 116));
    check("ovf_b2", drec[LAT+1], pk(50, 112, 46));
    check("ovf_b3", drec[LAT+2], pk(108, 42, 42));
    check("ovf_vend", vrec[LAT+3], 1'b0);

    // Random stream with random VIN against the reference model
    do_reset();
    H = (NT*NB)'({$urandom(), $urandom(), $urandom()});
    nrec = 0;
    nx = 0;
    blocks = 0;
    for (int t = 0; t < 1024; t++) ev[t] = 1'b0;
    while (blocks < 334 && nrec < 900) begin
      v  = ($urandom_range(0, 3) != 0);
      rd = (J*NB)'($urandom());
      if (v) begin
        for (int k = 0; k < J; k++) begin
          xv = rd[k*NB +: NB];
          xs[nx+k] = int'($signed(xv));
        end
        for (int k = 0; k < J; k++) yb[k*NB +: NB] = ymodel(nx + k);
        nx = nx + J;
        ev[nrec+LAT-1] = 1'b1;
        ed[nrec+LAT-1] = yb;
        blocks++;
      end
      apply(v, rd);
    end
    repeat (LAT) apply(1'b0, '0);
    check("rnd_blocks", blocks, 334);
    last = '0;
    for (int t = 0; t < nrec; t++) begin
      if (ev[t]) last = ed[t];
      check("rnd_vout", vrec[t], ev[t]);
      check("rnd_dout", drec[t], last);
    end

    // Mid-stream reset: nonzero history and DOUT from the random run
    H = hset(0, 32) | hset(1, 32);
    nrec = 0;
    apply(1'b1, pk(40, 40, 40));
    RST = 1'b1;
    apply(1'b1, pk(10, 10, 10));
    RST = 1'b0;
    apply(1'b1, pk(40, 0, 0));
    repeat (LAT) apply(1'b0, '0);
    for (int i = 0; i <= LAT+2; i++) check("mrst_vout", vrec[i], (i == LAT+1));
    check("mrst_dout0", drec[1], '0);
    check("mrst_dout1", drec[LAT+1], pk(20, 20, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
